// File: rtl/mano_pkg.sv
// Shared definitions for the basic-computer memory master: widths, opcodes, FSM states.
package mano_pkg;

  localparam int unsigned MANO_DW = 8;
  localparam int unsigned MANO_AW = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_LDA  = 3'b010;
  localparam logic [2:0] OP_STA  = 3'b011;
  localparam logic [2:0] OP_BUN  = 3'b100;
  localparam logic [2:0] OP_RREF = 3'b111;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StIndir,
    StOpnd,
    StStore,
    StIssue
  } mm_state_t;

  // Where a memory-reference instruction goes once its effective address is known.
  function automatic mm_state_t mm_dispatch(input logic needs_opnd, input logic is_sta);
    if (needs_opnd) begin
      return StOpnd;
    end else if (is_sta) begin
      return StStore;
    end
    return StIssue;
  endfunction

endpackage

// File: rtl/mano_ir_decode.sv
// Combinational classification of the instruction register.
module mano_ir_decode
  import mano_pkg::*;
(
  input  logic [MANO_DW-1:0] ir_i,
  output logic               is_rref_o,
  output logic               is_io_o,
  output logic               is_indirect_o,
  output logic               needs_opnd_o,
  output logic               is_sta_o,
  output logic               is_bun_o
);

  logic       ind;
  logic [2:0] op;

  assign ind = ir_i[7];
  assign op  = ir_i[6:4];

  assign is_rref_o     = (op == OP_RREF) && !ind;
  assign is_io_o       = (op == OP_RREF) && ind;
  // Opcode 111 uses the I bit as a class selector, not as an indirection flag.
  assign is_indirect_o = ind && (op != OP_RREF);
  assign needs_opnd_o  = (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  assign is_sta_o      = (op == OP_STA);
  assign is_bun_o      = (op == OP_BUN);

endmodule

// File: rtl/mano_mem_master.sv
// CPU-side memory initiator: fetch, decode, indirect resolve, operand/store access, issue.
module mano_mem_master
  import mano_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  output logic               read,
  output logic               write,
  output logic [MANO_AW-1:0] AR,
  output logic [MANO_DW-1:0] WDATA,
  input  logic [MANO_DW-1:0] RDATA,
  input  logic [MANO_DW-1:0] AC_IN,
  output logic               ISSUE_VALID,
  input  logic               ISSUE_READY,
  output logic               ISSUE_I,
  output logic [2:0]         ISSUE_OP,
  output logic [MANO_AW-1:0] ISSUE_ADDR,
  output logic [MANO_DW-1:0] ISSUE_OPND,
  output logic [MANO_AW-1:0] PC
);

  mm_state_t          state_q, state_d;
  logic [MANO_AW-1:0] pc_q, pc_d;
  logic [MANO_DW-1:0] ir_q, ir_d;
  logic [MANO_AW-1:0] ea_q, ea_d;
  logic [MANO_DW-1:0] opnd_q, opnd_d;

  logic is_rref, is_io, is_indirect, needs_opnd, is_sta, is_bun;

  mano_ir_decode u_decode (
    .ir_i          (ir_q),
    .is_rref_o     (is_rref),
    .is_io_o       (is_io),
    .is_indirect_o (is_indirect),
    .needs_opnd_o  (needs_opnd),
    .is_sta_o      (is_sta),
    .is_bun_o      (is_bun)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StBoot;
      pc_q    <= '0;
      ir_q    <= '0;
      ea_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ea_d    = ea_q;
    opnd_d  = opnd_q;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        ir_d    = RDATA;
        pc_d    = pc_q + 4'd1;
        // Non-operand instructions must issue a zero operand.
        opnd_d  = '0;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_rref || is_io) begin
          ea_d    = ir_q[3:0];
          state_d = StIssue;
        end else if (is_indirect) begin
          state_d = StIndir;
        end else begin
          ea_d    = ir_q[3:0];
          state_d = mm_dispatch(needs_opnd, is_sta);
          if (is_bun) begin
            pc_d = ir_q[3:0];
          end
        end
      end
      StIndir: begin
        ea_d    = RDATA[3:0];
        state_d = mm_dispatch(needs_opnd, is_sta);
        if (is_bun) begin
          pc_d = RDATA[3:0];
        end
      end
      StOpnd: begin
        opnd_d  = RDATA;
        state_d = StIssue;
      end
      StStore: state_d = StIssue;
      StIssue: begin
        if (ISSUE_READY) begin
          state_d = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Moore outputs: strobes and valid come only from the state register.
  always_comb begin
    read        = 1'b0;
    write       = 1'b0;
    AR          = pc_q;
    WDATA       = '0;
    ISSUE_VALID = 1'b0;
    ISSUE_I     = 1'b0;
    ISSUE_OP    = '0;
    ISSUE_ADDR  = '0;
    ISSUE_OPND  = '0;
    unique case (state_q)
      StFetch: read = 1'b1;
      StIndir: begin
        read = 1'b1;
        AR   = ir_q[3:0];
      end
      StOpnd: begin
        read = 1'b1;
        AR   = ea_q;
      end
      StStore: begin
        write = 1'b1;
        AR    = ea_q;
        WDATA = AC_IN;
      end
      StIssue: begin
        ISSUE_VALID = 1'b1;
        ISSUE_I     = ir_q[7];
        ISSUE_OP    = ir_q[6:4];
        ISSUE_ADDR  = ea_q;
        ISSUE_OPND  = opnd_q;
      end
      default: ;
    endcase
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_mano_mem_master.sv
// Directed bench for mano_mem_master against a 16x8 combinational-read memory model.
module tb_mano_mem_master;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       read, write, ISSUE_VALID, ISSUE_I;
  logic       ISSUE_READY = 1'b0;
  logic [3:0] AR, ISSUE_ADDR, PC;
  logic [7:0] WDATA, RDATA, ISSUE_OPND;
  logic [7:0] AC_IN = 8'h00;
  logic [2:0] ISSUE_OP;

  mano_mem_master dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .read        (read),
    .write       (write),
    .AR          (AR),
    .WDATA       (WDATA),
    .RDATA       (RDATA),
    .AC_IN       (AC_IN),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_READY (ISSUE_READY),
    .ISSUE_I     (ISSUE_I),
    .ISSUE_OP    (ISSUE_OP),
    .ISSUE_ADDR  (ISSUE_ADDR),
    .ISSUE_OPND  (ISSUE_OPND),
    .PC          (PC)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       load = 1'b0;

  assign RDATA = mem[AR];

  always @(posedge CLK) begin
    if (load) begin
      for (int k = 0; k < 16; k++) mem[k] <= img[k];
    end else if (write) begin
      mem[AR] <= WDATA;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0] tr_ar [32];
  logic [7:0] tr_wd [32];
  logic       tr_rd [32];
  logic       tr_wr [32];
  int         wr_cnt;
  int         overlap;

  // First sampled cycle is the FETCH cycle; returns the cycle index at which ISSUE_VALID is seen.
  task automatic wait_issue(output int cyc);
    cyc = 0;
    wr_cnt = 0;
    overlap = 0;
    do begin
      @(negedge CLK);
      cyc++;
      tr_ar[cyc] = AR;
      tr_wd[cyc] = WDATA;
      tr_rd[cyc] = read;
      tr_wr[cyc] = write;
      if (write) wr_cnt++;
      if (read && write) overlap++;
    end while (!ISSUE_VALID && cyc < 30);
    check("issue_seen", ISSUE_VALID, 1);
    check("rw_overlap", overlap, 0);
  endtask

  // Ends at a negedge with RST_N just released: the following sampled cycle is FETCH.
  task automatic do_reset();
    RST_N = 1'b0;
    load = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    load = 1'b0;
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_ar", AR, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_valid", ISSUE_VALID, 0);
    check("rst_op", {ISSUE_I, ISSUE_OP, ISSUE_ADDR, ISSUE_OPND}, 0);
    check("rst_pc", PC, 0);
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic [3:0] fpc;
    logic       i;
    logic [2:0] op;
    logic [3:0] addr;
    logic [7:0] opnd;
    logic [3:0] pc;
    int         cyc;
    logic [3:0] ar_pre;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int c, n;
    logic       s_i;
    logic [2:0] s_op;
    logic [3:0] s_addr;
    logic [7:0] s_opnd;

    img = '{8'h78, 8'h74, 8'h72, 8'h0A, 8'h1B, 8'h2C, 8'h47, 8'h8D,
            8'h9E, 8'hAF, 8'hC4, 8'hFF, 8'hFC, 8'h19, 8'h09, 8'h0B};

    // fetch pc, I, OP, EA, OPND, PC at issue, cycles, AR in cycle before issue
    tbl[0]  = '{4'h0, 1'b0, 3'd7, 4'h8, 8'h00, 4'h1, 3, 4'h0};
    tbl[1]  = '{4'h1, 1'b0, 3'd7, 4'h4, 8'h00, 4'h2, 3, 4'h0};
    tbl[2]  = '{4'h2, 1'b0, 3'd7, 4'h2, 8'h00, 4'h3, 3, 4'h0};
    tbl[3]  = '{4'h3, 1'b0, 3'd0, 4'hA, 8'hC4, 4'h4, 4, 4'hA};
    tbl[4]  = '{4'h4, 1'b0, 3'd1, 4'hB, 8'hFF, 4'h5, 4, 4'hB};
    tbl[5]  = '{4'h5, 1'b0, 3'd2, 4'hC, 8'hFC, 4'h6, 4, 4'hC};
    tbl[6]  = '{4'h6, 1'b0, 3'd4, 4'h7, 8'h00, 4'h7, 3, 4'h0};
    tbl[7]  = '{4'h7, 1'b1, 3'd0, 4'h9, 8'hAF, 4'h8, 5, 4'h9};
    tbl[8]  = '{4'h8, 1'b1, 3'd1, 4'h9, 8'hAF, 4'h9, 5, 4'h9};
    tbl[9]  = '{4'h9, 1'b1, 3'd2, 4'hB, 8'hFF, 4'hA, 5, 4'hB};
    tbl[10] = '{4'hA, 1'b1, 3'd4, 4'hB, 8'h00, 4'hB, 4, 4'h4};
    tbl[11] = '{4'hB, 1'b1, 3'd7, 4'hF, 8'h00, 4'hC, 3, 4'h0};
    tbl[12] = '{4'hC, 1'b1, 3'd7, 4'hC, 8'h00, 4'hD, 3, 4'h0};
    tbl[13] = '{4'hD, 1'b0, 3'd1, 4'h9, 8'hAF, 4'hE, 4, 4'h9};
    tbl[14] = '{4'hE, 1'b0, 3'd0, 4'h9, 8'hAF, 4'hF, 4, 4'h9};
    tbl[15] = '{4'hF, 1'b0, 3'd0, 4'hB, 8'hFF, 4'h0, 4, 4'hB};
    tbl[16] = '{4'h0, 1'b0, 3'd7, 4'h8, 8'h00, 4'h1, 3, 4'h0};

    // Free-running pass over the whole image, including the PC wrap.
    ISSUE_READY = 1'b1;
    do_reset();
    for (int v = 0; v < 17; v++) begin
      wait_issue(c);
      check("fetch_ar", tr_ar[1], tbl[v].fpc);
      check("fetch_read", tr_rd[1], 1);
      check("cycles", c, tbl[v].cyc);
      check("issue_i", ISSUE_I, tbl[v].i);
      check("issue_op", ISSUE_OP, tbl[v].op);
      check("issue_addr", ISSUE_ADDR, tbl[v].addr);
      check("issue_opnd", ISSUE_OPND, tbl[v].opnd);
      check("issue_pc", PC, tbl[v].pc);
      check("no_write", wr_cnt, 0);
      if (tbl[v].cyc >= 4) check("ar_pre", tr_ar[c - 1], tbl[v].ar_pre);
      if (tbl[v].i && tbl[v].cyc >= 4) check("indir_ar", tr_ar[3], tbl[v].fpc == 4'h7 ? 4'hD :
                                               tbl[v].fpc == 4'h8 ? 4'hE :
                                               tbl[v].fpc == 4'h9 ? 4'hF : 4'h4);
    end

    // Backpressure on the first issue.
    ISSUE_READY = 1'b0;
    do_reset();
    wait_issue(c);
    s_i = ISSUE_I; s_op = ISSUE_OP; s_addr = ISSUE_ADDR; s_opnd = ISSUE_OPND;
    check("bp_op", s_op, 7);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("bp_valid", ISSUE_VALID, 1);
      check("bp_payload", {ISSUE_I, ISSUE_OP, ISSUE_ADDR, ISSUE_OPND}, {s_i, s_op, s_addr, s_opnd});
      check("bp_read", read, 0);
      check("bp_write", write, 0);
      check("bp_pc", PC, 1);
    end
    ISSUE_READY = 1'b1;
    @(negedge CLK);
    check("bp_fetch_read", read, 1);
    check("bp_fetch_ar", AR, 1);
    check("bp_valid_drop", ISSUE_VALID, 0);

    // Direct STA.
    img[0] = 8'h35;
    AC_IN = 8'h5A;
    do_reset();
    wait_issue(c);
    check("sta_cycles", c, 4);
    check("sta_wr_cnt", wr_cnt, 1);
    check("sta_wr", tr_wr[3], 1);
    check("sta_ar", tr_ar[3], 5);
    check("sta_wdata", tr_wd[3], 8'h5A);
    check("sta_op", ISSUE_OP, 3);
    check("sta_addr", ISSUE_ADDR, 5);
    check("sta_opnd", ISSUE_OPND, 0);
    check("sta_mem", mem[5], 8'h5A);

    // Reset landing in the STORE cycle cancels the write.
    do_reset();
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!write && n < 20);
    check("store_seen", write, 1);
    RST_N = 1'b0;
    #1;
    check("abort_write", write, 0);
    check("abort_read", read, 0);
    check("abort_pc", PC, 0);
    check("abort_wdata", WDATA, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("abort_mem", mem[5], 8'h2C);
    RST_N = 1'b1;
    wait_issue(c);
    check("restart_fetch_ar", tr_ar[1], 0);
    check("restart_cycles", c, 4);
    check("restart_op", ISSUE_OP, 3);
    check("restart_wr_cnt", wr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mano_mem_master.md
# mano_mem_master

CPU-side initiator for the 16×8 basic-computer memory. Drives `read`/`write`/`AR`/`WDATA`, consumes the memory's combinational `RDATA`, and fetches and decodes instructions. It resolves indirect addresses, fetches operands, performs BUN and STA memory effects, and issues each decoded instruction to the execute stage over a valid/ready handshake. It sits between the memory block and the AC/ALU execute logic.

## Interface
- No parameters; widths fixed: data 8, address 4.
- `CLK` in 1: rising-edge clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `read` out 1: memory read strobe; memory data is valid combinationally in the same cycle.
- `write` out 1: memory write strobe, one cycle per STA.
- `AR` out 4: memory address.
- `WDATA` out 8: write data to the memory's `INDATA`.
- `RDATA` in 8: memory `OUTDATA`.
- `AC_IN` in 8: accumulator value, sampled for STA.
- `ISSUE_VALID` out 1: decoded instruction available.
- `ISSUE_READY` in 1: execute stage accepts.
- `ISSUE_I` out 1: IR[7], the indirect bit.
- `ISSUE_OP` out 3: IR[6:4], the opcode.
- `ISSUE_ADDR` out 4: effective address (EA); IR[3:0] for register-reference and I/O instructions.
- `ISSUE_OPND` out 8: operand for AND/ADD/LDA, 0 otherwise.
- `PC` out 4: program counter.

## Operation
- Instruction format: I=IR[7], OP=IR[6:4], ADDR=IR[3:0].
- Opcodes: AND=000, ADD=001, LDA=010, STA=011, BUN=100; 101/110 are memory-reference no-ops; 111 is register-reference (I=0) or I/O (I=1).
- States: BOOT, FETCH, DECODE, INDIR, OPND, STORE, ISSUE.
- **BOOT** (reset state): no access. → FETCH.
- **FETCH**: AR=PC, read=1.
  - IR ← RDATA.
  - PC ← PC+1, mod 16 (15 wraps to 0).
  - → DECODE.
- **DECODE**: no access.
  - OP=111: EA←ADDR, → ISSUE.
  - I=1 (OP≠111): → INDIR.
  - I=0: EA←ADDR, then
    - AND/ADD/LDA → OPND,
    - STA → STORE,
    - BUN: PC←ADDR, → ISSUE,
    - 101/110 → ISSUE.
- **INDIR**: AR=IR[3:0], read=1.
  - EA ← RDATA[3:0]; RDATA[7:4] is ignored.
  - Next state follows the I=0 dispatch above; BUN loads PC←RDATA[3:0] on this edge.
- **OPND**: AR=EA, read=1. OPND ← RDATA. → ISSUE.
- **STORE**: AR=EA, write=1, WDATA=AC_IN. → ISSUE.
- **ISSUE**: ISSUE_VALID=1; payload registered and stable. On an edge with ISSUE_READY=1 → FETCH; otherwise hold.
- AR in BOOT/DECODE/ISSUE equals PC.
- WDATA is 0 outside STORE.
- read and write are never both high.
- Every instruction, including BUN and STA, is issued exactly once.
- Memory strobes and ISSUE_VALID are decoded from the state register (Moore), with no combinational path from ISSUE_READY.

## Timing
- Reset values: state=BOOT, PC=0, IR=0, EA=0, OPND=0; read=0, write=0, ISSUE_VALID=0, AR=0, WDATA=0, all ISSUE_* = 0.
- RST_N low mid-operation aborts immediately:
  - strobes drop asynchronously,
  - an in-progress STORE write is cancelled,
  - an un-accepted issue is lost.
- Cycles from FETCH to first ISSUE cycle, with ISSUE_READY held high:

| Instruction | Cycles |
|---|---|
| register-reference, I/O, direct BUN, 101/110 | 3 |
| direct AND/ADD/LDA, direct STA | 4 |
| indirect AND/ADD/LDA/STA | 5 |
| indirect BUN, indirect 101/110 | 4 |

- Back-to-back throughput: the next FETCH follows the accept edge directly, with no bubble.
- Backpressure: ISSUE_VALID and payload hold unchanged for any number of cycles; no memory access occurs while stalled.
- PC is already incremented (or branched) before ISSUE, so `PC` shows the next-fetch address while the instruction is issued.

## Structure
- Shared package `mano_pkg`:
  - opcode constants (OP_AND … OP_RREF),
  - state enum `mm_state_t`,
  - widths `MANO_DW=8`, `MANO_AW=4`.
- Sub-module `mano_ir_decode`: combinational decode of IR into is_rref, is_io, is_indirect, needs_opnd, is_sta, is_bun. Instantiated once.

## Test plan
All scenarios use the standard 16-word image (MEM[0..15] = 78 74 72 0A 1B 2C 47 8D 9E AF C4 FF FC 19 09 0B) unless noted; ISSUE_READY=1 unless noted.
1. Release reset → first issue is OP=111, I=0, ADDR=8, OPND=0, 3 cycles after FETCH; PC=1.
2. Run to PC=3 → AND issued with ADDR=A, OPND=C4; then ADD with ADDR=B, OPND=FF.
3. Instruction at 7 (0x8D, indirect AND) → INDIR reads AR=D, giving EA=9; OPND read at AR=9; issue ADDR=9, OPND=AF in 5 cycles.
4. Instruction at A (0xC4, indirect BUN) → INDIR at AR=4 reads 1B; PC=B at issue; next FETCH has AR=B.
5. MEM[0]=0x35, AC_IN=5A → exactly one cycle of write=1, AR=5, WDATA=5A; then issue OP=011, ADDR=5.
6. Backpressure and reset:
   - ISSUE_READY=0 for 4 cycles at the first issue → payload stable, read=0 throughout, FETCH after release.
   - RST_N pulsed low during STORE → write drops immediately, PC=0, restart from BOOT.
   - PC=F fetch → PC wraps to 0.
